// File: rtl/pattern_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pattern_sequencer_if
// Purpose  : Bundles the transport commands, the pattern write port and the
//            channel frequency / status outputs of pattern_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pattern_sequencer_if #(
  parameter int FREQ_WIDTH = 12,
  parameter int ADDR_WIDTH = 4
);
  // transport commands
  logic                  play;
  logic                  pause;
  logic                  stop;
  logic                  loop_en;
  // pattern write port
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_step;
  logic [1:0]            wr_chan;
  logic [FREQ_WIDTH-1:0] wr_freq;
  // channel controls and status
  logic [FREQ_WIDTH-1:0] freq1;
  logic [FREQ_WIDTH-1:0] freq2;
  logic [FREQ_WIDTH-1:0] freq3;
  logic [FREQ_WIDTH-1:0] freq4;
  logic [ADDR_WIDTH-1:0] cur_step;
  logic                  step_tick;
  logic                  playing;

  modport master (
    output play, pause, stop, loop_en, wr_en, wr_step, wr_chan, wr_freq,
    input  freq1, freq2, freq3, freq4, cur_step, step_tick, playing
  );

  modport slave (
    input  play, pause, stop, loop_en, wr_en, wr_step, wr_chan, wr_freq,
    output freq1, freq2, freq3, freq4, cur_step, step_tick, playing
  );
endinterface
`default_nettype wire

// File: rtl/pattern_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pattern_sequencer
// Purpose  : Tempo-driven step sequencer. Holds a STEPS-deep pattern of four
//            frequency words per step and plays it out on freq1..freq4, one
//            step every TICK_DIV clocks. A frequency word of 0 is silence.
// Options  : SEQ_LIVE_UPDATE_EN - while playing, writes to the current step
//            reach the outputs on the following edge instead of waiting for
//            the next load of that step.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_sequencer #(
  parameter int FREQ_WIDTH = 12,
  parameter int STEPS      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int TICK_WIDTH = 24,
  parameter int TICK_DIV   = 6000000
) (
  input  logic                clk,
  input  logic                rst_n,
  pattern_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICK_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP_LAST = ADDR_WIDTH'(STEPS - 1);

  // pattern storage: deliberately not reset
  logic [FREQ_WIDTH-1:0] pattern_mem [STEPS][4];

  logic [1:0]            state_q,     state_d;
  logic [TICK_WIDTH-1:0] tick_cnt_q,  tick_cnt_d;
  logic [ADDR_WIDTH-1:0] cur_step_q,  cur_step_d;
  logic [FREQ_WIDTH-1:0] freq_q [4];
  logic [FREQ_WIDTH-1:0] freq_d [4];
  logic                  step_tick_q, step_tick_d;

  // resolved commands: stop beats pause, pause beats play
  logic cmd_stop, cmd_pause, cmd_play;
  logic tick_end, last_step;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_step;

  assign cmd_stop  = bus.stop;
  assign cmd_pause = bus.pause & ~bus.stop;
  assign cmd_play  = bus.play & ~bus.pause & ~bus.stop;
  assign tick_end  = (tick_cnt_q == TICK_LAST);
  assign last_step = (cur_step_q == STEP_LAST);

  // pattern write port; the read side sees the old word on the write edge
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      pattern_mem[bus.wr_step][bus.wr_chan] <= bus.wr_freq;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      cur_step_q  <= '0;
      step_tick_q <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        freq_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      cur_step_q  <= cur_step_d;
      step_tick_q <= step_tick_d;
      for (int c = 0; c < 4; c++) begin
        freq_q[c] <= freq_d[c];
      end
    end
  end

  // transport state transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_play) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (cmd_stop)                                     state_d = ST_IDLE;
        else if (cmd_pause)                               state_d = ST_PAUSE;
        else if (tick_end && last_step && !bus.loop_en)   state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        if (cmd_stop)      state_d = ST_IDLE;
        else if (cmd_play) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tempo counter, step pointer and channel outputs for the coming cycle
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    cur_step_d  = cur_step_q;
    freq_d      = freq_q;
    step_tick_d = 1'b0;
    load_en     = 1'b0;
    load_step   = cur_step_q;

    case (state_q)
      ST_PLAY: begin
        if (state_d == ST_IDLE) begin
          // stopped, or ran off the end without looping
          tick_cnt_d = '0;
          cur_step_d = '0;
          for (int c = 0; c < 4; c++) freq_d[c] = '0;
        end else if (state_d == ST_PAUSE) begin
          // silence the channels, keep position for resume
          for (int c = 0; c < 4; c++) freq_d[c] = '0;
        end else if (tick_end) begin
          tick_cnt_d  = '0;
          step_tick_d = 1'b1;
          load_en     = 1'b1;
          load_step   = last_step ? '0 : cur_step_q + ADDR_WIDTH'(1);
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_WIDTH'(1);
`ifdef SEQ_LIVE_UPDATE_EN
          // refresh from memory so a write to this step shows one edge later
          load_en    = 1'b1;
          load_step  = cur_step_q;
`endif
        end
      end
      ST_PAUSE: begin
        if (state_d == ST_IDLE) begin
          tick_cnt_d = '0;
          cur_step_d = '0;
          for (int c = 0; c < 4; c++) freq_d[c] = '0;
        end else if (state_d == ST_PLAY) begin
          // resume: same step, counter continues from where it froze
          load_en   = 1'b1;
          load_step = cur_step_q;
        end
      end
      default: begin
        tick_cnt_d = '0;
        cur_step_d = '0;
        for (int c = 0; c < 4; c++) freq_d[c] = '0;
        if (state_d == ST_PLAY) begin
          step_tick_d = 1'b1;
          load_en     = 1'b1;
          load_step   = '0;
        end
      end
    endcase

    if (load_en) begin
      cur_step_d = load_step;
      for (int c = 0; c < 4; c++) freq_d[c] = pattern_mem[load_step][c];
    end
  end

  assign bus.freq1     = freq_q[0];
  assign bus.freq2     = freq_q[1];
  assign bus.freq3     = freq_q[2];
  assign bus.freq4     = freq_q[3];
  assign bus.cur_step  = cur_step_q;
  assign bus.step_tick = step_tick_q;
  assign bus.playing   = (state_q == ST_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pattern_sequencer
// Purpose  : Self-checking bench for pattern_sequencer with a fast tempo
//            (TICK_DIV = 4) and a behavioural model of the transport rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_sequencer;

  localparam int TD = 4;
  localparam int NS = 16;

  logic clk;
  logic rst_n;

  pattern_sequencer_if #(.FREQ_WIDTH(12), .ADDR_WIDTH(4)) bif ();

  pattern_sequencer #(
    .FREQ_WIDTH(12), .STEPS(NS), .ADDR_WIDTH(4), .TICK_WIDTH(24), .TICK_DIV(TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural model ----------------
  // mode: 0 stopped, 1 playing, 2 paused
  int m_mode;
  int m_step;
  int m_elapsed;          // whole cycles already spent in the current step
  int m_freq [4];
  int m_tick;
  int m_mem  [NS][4];

  function automatic void m_show(input int k);
    for (int c = 0; c < 4; c++) m_freq[c] = m_mem[k][c];
  endfunction

  function automatic void m_go_idle();
    m_mode = 0; m_step = 0; m_elapsed = 0;
    for (int c = 0; c < 4; c++) m_freq[c] = 0;
  endfunction

  function automatic void m_reset();
    m_go_idle();
    m_tick = 0;
  endfunction

  function automatic void m_apply(input int p, input int pa, input int s, input int lp,
                                  input int we, input int ws, input int wc, input int wf);
    m_tick = 0;
    if (s) begin
      m_go_idle();
    end else if (pa) begin
      if (m_mode == 1) begin
        m_mode = 2;
        for (int c = 0; c < 4; c++) m_freq[c] = 0;
      end
    end else if (p && m_mode == 0) begin
      m_mode = 1; m_step = 0; m_elapsed = 0; m_show(0); m_tick = 1;
    end else if (p && m_mode == 2) begin
      m_mode = 1; m_show(m_step);
    end else if (m_mode == 1) begin
      m_elapsed++;
      if (m_elapsed == TD) begin
        if (m_step < NS - 1) begin
          m_step++; m_elapsed = 0; m_show(m_step); m_tick = 1;
        end else if (lp) begin
          m_step = 0; m_elapsed = 0; m_show(0); m_tick = 1;
        end else begin
          m_go_idle();
        end
      end else begin
`ifdef SEQ_LIVE_UPDATE_EN
        m_show(m_step);
`endif
      end
    end
    if (we) m_mem[ws][wc] = wf;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    chk("freq1",     bif.freq1,     m_freq[0]);
    chk("freq2",     bif.freq2,     m_freq[1]);
    chk("freq3",     bif.freq3,     m_freq[2]);
    chk("freq4",     bif.freq4,     m_freq[3]);
    chk("cur_step",  bif.cur_step,  m_step);
    chk("step_tick", bif.step_tick, m_tick);
    chk("playing",   bif.playing,   (m_mode == 1) ? 1 : 0);
  endtask

  // one clock: drive at negedge, model at posedge, check at next negedge
  task automatic cyc(input int p, input int pa, input int s,
                     input int we, input int ws, input int wc, input int wf);
    bif.play    = p[0];
    bif.pause   = pa[0];
    bif.stop    = s[0];
    bif.wr_en   = we[0];
    bif.wr_step = ws[3:0];
    bif.wr_chan = wc[1:0];
    bif.wr_freq = wf[11:0];
    @(posedge clk);
    m_apply(p, pa, s, int'(bif.loop_en), we, ws, wc, wf);
    @(negedge clk);
    check_outputs();
    bif.play  = 1'b0;
    bif.pause = 1'b0;
    bif.stop  = 1'b0;
    bif.wr_en = 1'b0;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n       = 1'b0;
    bif.play    = 1'b0;
    bif.pause   = 1'b0;
    bif.stop    = 1'b0;
    bif.loop_en = 1'b0;
    bif.wr_en   = 1'b0;
    bif.wr_step = '0;
    bif.wr_chan = '0;
    bif.wr_freq = '0;
    for (int k = 0; k < NS; k++) for (int c = 0; c < 4; c++) m_mem[k][c] = 0;
    m_reset();

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_freq1", bif.freq1, 0);
    chk("rst_freq4", bif.freq4, 0);
    chk("rst_cur_step", bif.cur_step, 0);
    chk("rst_step_tick", bif.step_tick, 0);
    chk("rst_playing", bif.playing, 0);
    rst_n = 1'b1;

    // load pattern: step k channel N = 16*k + N
    for (int k = 0; k < NS; k++)
      for (int c = 0; c < 4; c++)
        cyc(0, 0, 0, 1, k, c, 16 * k + c + 1);

    // single pass, no loop
    bif.loop_en = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("start_freq1", bif.freq1, 1);
    chk("start_freq4", bif.freq4, 4);
    chk("start_tick", bif.step_tick, 1);
    n = 0;
    while (bif.playing && n < 100) begin idle_cyc(); n++; end
    chk("pass_length", n, NS * TD);
    chk("end_freq1", bif.freq1, 0);
    chk("end_cur_step", bif.cur_step, 0);

    // looping: step 15 wraps back to step 0
    bif.loop_en = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (bif.cur_step != 4'd15 && n < 100) begin idle_cyc(); n++; end
    chk("s15_freq1", bif.freq1, 241);
    n = 0;
    while (bif.cur_step != 4'd0 && n < 10) begin idle_cyc(); n++; end
    chk("wrap_freq1", bif.freq1, 1);
    chk("wrap_tick", bif.step_tick, 1);
    chk("wrap_playing", bif.playing, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);

    // pause two cycles into step 3, resume after 20 cycles
    bif.loop_en = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (bif.cur_step != 4'd3 && n < 40) begin idle_cyc(); n++; end
    idle_cyc();
    idle_cyc();
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("pause_freq1", bif.freq1, 0);
    chk("pause_playing", bif.playing, 0);
    chk("pause_step", bif.cur_step, 3);
    repeat (20) idle_cyc();
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("resume_freq1", bif.freq1, 49);
    chk("resume_tick", bif.step_tick, 0);
    n = 0;
    while (bif.cur_step == 4'd3 && n < 10) begin idle_cyc(); n++; end
    chk("resume_advance", n, 2);

    // stop and pause together
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("sp_cur_step", bif.cur_step, 0);
    chk("sp_playing", bif.playing, 0);
    chk("sp_freq2", bif.freq2, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("restart_step", bif.cur_step, 0);
    chk("restart_freq1", bif.freq1, 1);

    // write step 5 channel 2 on the edge that loads step 5
    n = 0;
    while (!(m_mode == 1 && m_step == 4 && m_elapsed == TD - 1) && n < 40) begin idle_cyc(); n++; end
    cyc(0, 0, 0, 1, 5, 1, 12'hABC);
    chk("rbw_step", bif.cur_step, 5);
    chk("rbw_freq2", bif.freq2, 82);
    idle_cyc();
`ifdef SEQ_LIVE_UPDATE_EN
    chk("live_freq2", bif.freq2, 12'hABC);
`else
    chk("held_freq2", bif.freq2, 82);
`endif
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (bif.cur_step != 4'd5 && n < 40) begin idle_cyc(); n++; end
    chk("reload_freq2", bif.freq2, 12'hABC);
    cyc(0, 0, 1, 0, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r, we;
      r  = int'($urandom_range(0, 99));
      we = ($urandom_range(0, 4) == 0) ? 1 : 0;
      bif.loop_en = ($urandom_range(0, 3) != 0);
      cyc((r < 6) ? 1 : 0, (r >= 6 && r < 9) ? 1 : 0, (r == 9) ? 1 : 0,
          we, int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 4095)));
    end

    // asynchronous reset in the middle of step 7
    cyc(0, 0, 1, 0, 0, 0, 0);
    bif.loop_en = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (!(m_step == 7 && m_elapsed == 1) && n < 60) begin idle_cyc(); n++; end
    chk("reach_s7", bif.cur_step, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_freq1", bif.freq1, 0);
    chk("arst_freq3", bif.freq3, 0);
    chk("arst_playing", bif.playing, 0);
    chk("arst_cur_step", bif.cur_step, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("intact_s0c1", bif.freq1, m_mem[0][0]);
    repeat (12) idle_cyc();
    chk("intact_step", bif.cur_step, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
